config_usb_readback: RTL and testbench

Upload-direction counterpart of the DFU bitstream download path. It answers DFU_UPLOAD requests on alternate setting 2 by fetching 32-bit configuration words from a word-wide readback port and serializing them MSB-first onto the USB_DFU IN byte stream. Each upload is preceded by a 4-byte header. The block sits between USB_DFU and the fabric configuration readback logic.

---
 rtl/config_usb_readback.sv | 186 ++++++++++++++++++
 tb/tb_config_usb_readback.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_usb_readback.sv
// config_usb_readback: serves DFU_UPLOAD on alternate setting 2.
// A 4-byte header (00 AA FF HEADER_CMD) is sent first. Then 32-bit words are
// fetched from the readback port and sent MSB-first onto the DFU IN byte stream.
// Optional feature macro: CONFIG_USB_READBACK_CHECKSUM_EN. When it is defined, an
// 8-bit XOR of all payload bytes is appended as the last byte of the upload.
module config_usb_readback #(
  parameter int         WORD_COUNT = 'd1024,
  parameter int         ADDR_WIDTH = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1,
  parameter logic [7:0] HEADER_CMD = 8'h81
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dfu_mode_i,
  input  logic [2:0]            dfu_alt_i,
  input  logic                  dfu_in_en_i,
  output logic [7:0]            dfu_in_data_o,
  output logic                  dfu_in_valid_o,
  input  logic                  dfu_in_ready_i,
  output logic                  word_read_strobe_o,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  input  logic [31:0]           read_data_i,
  input  logic                  read_valid_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_WAIT,
    S_SEND,
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t                state;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_cnt;
  // Holds the not-yet-presented bytes of the current word, next byte in [23:16].
  logic [23:0]           shift_reg;
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic active;
  logic xfer;
  logic last_word;

  // Upload qualification, byte handshake and end-of-upload detection.
  always_comb begin
    active    = dfu_mode_i && (dfu_alt_i == 3'd2) && dfu_in_en_i;
    xfer      = dfu_in_valid_o && dfu_in_ready_i;
    last_word = (word_cnt == ADDR_WIDTH'(WORD_COUNT - 1));
  end

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_byte = 8'h00;
      2'd1:    hdr_byte = 8'hAA;
      2'd2:    hdr_byte = 8'hFF;
      default: hdr_byte = HEADER_CMD;
    endcase
  endfunction

  // Upload sequencer. All outputs are registered here. An abort (active falling)
  // is checked before any state-specific action, so a pending byte is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state              <= S_IDLE;
      byte_idx           <= 2'd0;
      word_cnt           <= '0;
      shift_reg          <= '0;
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
      csum               <= 8'h00;
`endif
      dfu_in_data_o      <= 8'h00;
      dfu_in_valid_o     <= 1'b0;
      word_read_strobe_o <= 1'b0;
      read_addr_o        <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else if (state != S_IDLE && !active) begin
      state              <= S_IDLE;
      dfu_in_valid_o     <= 1'b0;
      word_read_strobe_o <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      word_read_strobe_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (active) begin
            state          <= S_HDR;
            byte_idx       <= 2'd0;
            word_cnt       <= '0;
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
            csum           <= 8'h00;
`endif
            dfu_in_data_o  <= hdr_byte(2'd0);
            dfu_in_valid_o <= 1'b1;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            if (byte_idx == 2'd3) begin
              state              <= S_REQ;
              dfu_in_valid_o     <= 1'b0;
              word_read_strobe_o <= 1'b1;
              read_addr_o        <= word_cnt;
            end else begin
              byte_idx      <= byte_idx + 2'd1;
              dfu_in_data_o <= hdr_byte(byte_idx + 2'd1);
            end
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (read_valid_i) begin
            state          <= S_SEND;
            byte_idx       <= 2'd0;
            shift_reg      <= read_data_i[23:0];
            dfu_in_data_o  <= read_data_i[31:24];
            dfu_in_valid_o <= 1'b1;
          end
        end
        S_SEND: begin
          if (xfer) begin
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
            csum <= csum ^ dfu_in_data_o;
`endif
            if (byte_idx == 2'd3) begin
              if (last_word) begin
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
                // The checksum byte already folds in the byte being consumed now.
                state          <= S_CSUM;
                dfu_in_data_o  <= csum ^ dfu_in_data_o;
                dfu_in_valid_o <= 1'b1;
`else
                state          <= S_DONE;
                dfu_in_valid_o <= 1'b0;
                busy_o         <= 1'b0;
                done_o         <= 1'b1;
`endif
              end else begin
                state              <= S_REQ;
                dfu_in_valid_o     <= 1'b0;
                word_cnt           <= word_cnt + ADDR_WIDTH'(1);
                read_addr_o        <= word_cnt + ADDR_WIDTH'(1);
                word_read_strobe_o <= 1'b1;
              end
            end else begin
              byte_idx      <= byte_idx + 2'd1;
              dfu_in_data_o <= shift_reg[23:16];
              shift_reg     <= {shift_reg[15:0], 8'h00};
            end
          end
        end
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state          <= S_DONE;
            dfu_in_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          done_o         <= 1'b1;
          dfu_in_valid_o <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_usb_readback.sv
// Testbench for config_usb_readback (WORD_COUNT = 2). The expected upload is
// built from the byte-stream rules: header, then the words MSB-first, then an
// optional XOR byte. A negedge monitor records consumed bytes and strobes.
module tb_config_usb_readback;
  localparam int WC = 2;
  localparam int AW = 1;
`ifdef CONFIG_USB_READBACK_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, mode, en;
  logic [2:0]    alt;
  logic [7:0]    data;
  logic          valid;
  logic          ready = 1'b0;
  logic          strobe;
  logic [AW-1:0] addr;
  logic [31:0]   rdata = 32'h0;
  logic          rvalid = 1'b0;
  logic          busy, done;

  // Control knobs written only by the main sequence.
  logic        resp_en, ready_rand, ready_force, rv_manual;
  logic [31:0] manual_data;
  int          lat;
  logic [31:0] mem [WC];

  // Monitor state, written only by the monitor.
  logic [7:0]    bytes[$];
  logic [AW-1:0] strobes[$];
  int            hold_err = 0, valid_cnt = 0, strobe_cnt = 0, busy_cnt = 0;
  logic          prev_hold = 1'b0;
  logic [7:0]    prev_data = 8'h00;

  // Responder state.
  int            cnt = 0;
  logic [AW-1:0] pend = '0;

  // Main-sequence bookkeeping.
  int          n_assert = 0, n_fail = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  config_usb_readback #(.WORD_COUNT(WC), .ADDR_WIDTH(AW), .HEADER_CMD(8'h81)) dut (
    .clk_i(clk), .reset_i(reset), .dfu_mode_i(mode), .dfu_alt_i(alt),
    .dfu_in_en_i(en), .dfu_in_data_o(data), .dfu_in_valid_o(valid),
    .dfu_in_ready_i(ready), .word_read_strobe_o(strobe), .read_addr_o(addr),
    .read_data_i(rdata), .read_valid_i(rvalid), .busy_o(busy), .done_o(done)
  );

  // Ready driver and readback memory with programmable latency after the strobe.
  always @(posedge clk) begin
    #1;
    ready  = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    rvalid = 1'b0;
    if (rv_manual) begin
      rvalid = 1'b1;
      rdata  = manual_data;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        rvalid = 1'b1;
        rdata  = mem[pend];
      end
    end
    if (strobe === 1'b1 && resp_en) begin
      cnt  = lat;
      pend = addr;
    end
  end

  // Monitor: sampled mid-cycle once inputs have settled for the coming edge.
  always @(negedge clk) begin
    logic act;
    #2;
    act = mode && (alt == 3'd2) && en && !reset;
    if (valid === 1'b1 && ready === 1'b1 && act) bytes.push_back(data);
    if (prev_hold && act && !(valid === 1'b1 && data === prev_data)) hold_err++;
    prev_hold = (valid === 1'b1) && (ready === 1'b0) && act;
    prev_data = data;
    if (strobe === 1'b1) begin
      strobes.push_back(addr);
      strobe_cnt++;
    end
    if (valid === 1'b1) valid_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference upload contents, from the memory image.
  task automatic build_exp();
    logic [7:0] x;
    exp_q = {8'h00, 8'hAA, 8'hFF, 8'h81};
    x = 8'h00;
    for (int w = 0; w < WC; w++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(8'((mem[w] >> (8 * b)) & 32'hFF));
        x = x ^ 8'((mem[w] >> (8 * b)) & 32'hFF);
      end
    end
    if (CS == 1) exp_q.push_back(x);
  endtask

  task automatic check_stream(input int base, input string tag);
    build_exp();
    check(bytes.size() - base, exp_q.size(), {tag, "_len"});
    for (int i = 0; i < exp_q.size() && base + i < bytes.size(); i++)
      check(bytes[base + i], exp_q[i], $sformatf("%s_byte%0d", tag, i));
  endtask

  task automatic check_strobes(input int sbase, input string tag);
    check(strobes.size() - sbase, WC, {tag, "_nstrobe"});
    for (int i = 0; i < WC && sbase + i < strobes.size(); i++)
      check(strobes[sbase + i], i, $sformatf("%s_addr%0d", tag, i));
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < bound) begin
      step();
      cycles++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(data, 8'h00, {tag, "_data"});
    check(valid, 1'b0, {tag, "_valid"});
    check(strobe, 1'b0, {tag, "_strobe"});
    check(addr, '0, {tag, "_addr"});
    check(busy, 1'b0, {tag, "_busy"});
    check(done, 1'b0, {tag, "_done"});
  endtask

  initial begin
    int base, sbase, cycles, hb, vb, sb, bb, nb;
    reset = 1'b1; mode = 1'b0; alt = 3'd0; en = 1'b0;
    resp_en = 1'b1; ready_rand = 1'b0; ready_force = 1'b1; rv_manual = 1'b0;
    manual_data = 32'h0; lat = 1;
    mem[0] = 32'h01020304; mem[1] = 32'hA5A5A5A5;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Directed upload, ready high, 1-cycle read latency.
    base = bytes.size(); sbase = strobes.size();
    mode = 1'b1; alt = 3'd2; en = 1'b1;
    step();
    check(valid, 1'b1, "hdr_latency_valid");
    check(data, 8'h00, "hdr_latency_data");
    check(busy, 1'b1, "hdr_busy");
    wait_done(400, cycles);
    check(cycles, 1 + 4 + 6 * WC + CS, "t1_cycles");
    check(done, 1'b1, "t1_done");
    check(busy, 1'b0, "t1_busy_after");
    check(valid, 1'b0, "t1_valid_after");
    check_stream(base, "t1");
    check_strobes(sbase, "t1");

    // read_valid pulsed in DONE is ignored.
    nb = bytes.size();
    rv_manual = 1'b1; manual_data = 32'hDEADBEEF;
    step();
    rv_manual = 1'b0;
    repeat (3) step();
    check(bytes.size(), nb, "done_rv_bytes");
    check(done, 1'b1, "done_rv_done");
    check(valid, 1'b0, "done_rv_valid");
    en = 1'b0;
    step();
    check(done, 1'b0, "done_exit");

    // read_valid pulsed in IDLE is ignored.
    sb = strobe_cnt; vb = valid_cnt;
    rv_manual = 1'b1;
    step();
    rv_manual = 1'b0;
    repeat (3) step();
    check(valid_cnt - vb, 0, "idle_rv_valid");
    check(strobe_cnt - sb, 0, "idle_rv_strobe");
    check(busy, 1'b0, "idle_rv_busy");

    // Random data, random ready, 3-cycle read latency.
    mem[0] = $urandom(); mem[1] = $urandom();
    lat = 3; ready_rand = 1'b1;
    base = bytes.size(); sbase = strobes.size(); hb = hold_err;
    en = 1'b1;
    step();
    wait_done(2000, cycles);
    check(done, 1'b1, "t2_done");
    check_stream(base, "t2");
    check_strobes(sbase, "t2");
    check(hold_err - hb, 0, "t2_hold_stable");
    ready_rand = 1'b0; lat = 1;
    en = 1'b0;
    repeat (2) step();

    // Wrong alternate setting: nothing happens.
    alt = 3'd0; en = 1'b1;
    vb = valid_cnt; sb = strobe_cnt; bb = busy_cnt;
    repeat (20) step();
    check(valid_cnt - vb, 0, "alt0_valid");
    check(strobe_cnt - sb, 0, "alt0_strobe");
    check(busy_cnt - bb, 0, "alt0_busy");
    en = 1'b0; alt = 3'd2;
    step();

    // Abort during word 0 byte 2, then restart.
    mem[0] = 32'h11223344; mem[1] = 32'h55667788;
    base = bytes.size();
    en = 1'b1;
    cycles = 0;
    while (!(valid === 1'b1 && data === 8'h33) && cycles < 100) begin
      step();
      cycles++;
    end
    check(data, 8'h33, "abort_reached");
    en = 1'b0;
    step();
    check(valid, 1'b0, "abort_valid");
    check(busy, 1'b0, "abort_busy");
    check(bytes.size() - base, 6, "abort_len");
    if (bytes.size() >= base + 6) begin
      check(bytes[base + 4], 8'h11, "abort_b4");
      check(bytes[base + 5], 8'h22, "abort_b5");
    end
    step();
    base = bytes.size(); sbase = strobes.size();
    en = 1'b1;
    step();
    check(data, 8'h00, "restart_hdr");
    wait_done(400, cycles);
    check(done, 1'b1, "restart_done");
    check_stream(base, "restart");
    check_strobes(sbase, "restart");
    en = 1'b0;
    repeat (2) step();

    // Reset in WAIT coinciding with read_valid.
    resp_en = 1'b0;
    base = bytes.size();
    en = 1'b1;
    cycles = 0;
    while (strobe !== 1'b1 && cycles < 50) begin
      step();
      cycles++;
    end
    check(strobe, 1'b1, "rstwait_strobe");
    rv_manual = 1'b1; manual_data = 32'hDEADBEEF;
    step();
    reset = 1'b1; en = 1'b0; rv_manual = 1'b0;
    step();
    check_reset_outputs("rstwait");
    reset = 1'b0;
    repeat (3) step();
    check(bytes.size() - base, 4, "rstwait_no_data");
    check(valid, 1'b0, "rstwait_valid_after");
    resp_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
